mult_share_arb: RTL
===================

# mult_share_arb

Round-robin arbiter and sequencer sharing one signed 8x8 shift-add multiplier datapath between two requesters. It captures a winning requester's operands, issues a one-cycle start to the datapath, and waits for completion with a timeout. It then returns the 16-bit product tagged with the requester id. It sits between the two client blocks and the multiplier datapath; the clients never drive the datapath directly.

## Interface
- TIMEOUT, 24: WAIT-state cycles allowed before abandoning an operation; legal range 2..31.
- clk  in  1  system clock, all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from port 0 / 1; held high until the matching grant
- a0, b0 / a1, b1  in  8 each  signed operands for port 0 / 1; stable while req is high
- gnt0 / gnt1  out  1  one-cycle pulse; operands for that port have been captured
- mult_start  out  1  one-cycle start pulse to the datapath
- mult_A, mult_B  out  8 each  captured operands; held stable from START through WAIT
- mult_done  in  1  datapath completion; level signal, may stay high from the previous operation
- mult_out  in  16  datapath product; valid while mult_done is high
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  port the response belongs to
- rsp_data  out  16  product; 0 on timeout
- rsp_timeout  out  1  response was produced by timeout, not by mult_done
- busy  out  1  high whenever state is not IDLE

## Operation
- States are IDLE, START, WAIT and RESP. Registers: opA/opB (8), cur_id, last_id, timer (5), rsp_data, rsp_timeout.
- **IDLE**
  - If exactly one req is high, that port wins.
  - If both are high, the port not equal to last_id wins.
  - At the edge: capture the winner's a/b into opA/opB, set cur_id, go to START.
  - With no req, stay in IDLE.
- **START**
  - gnt[cur_id]=1 and mult_start=1 for exactly this cycle.
  - mult_A/mult_B = opA/opB.
  - Clear timer, go to WAIT.
- **WAIT**
  - timer increments each cycle.
  - mult_done is ignored while timer==0, because of a stale level from the previous operation.
  - If timer>=1 and mult_done=1: capture mult_out into rsp_data, rsp_timeout=0, go to RESP.
  - Otherwise, if timer==TIMEOUT: rsp_data=0, rsp_timeout=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- **RESP**
  - rsp_valid=1 and rsp_id=cur_id.
  - Set last_id=cur_id, go to IDLE.
- Operands and product pass through unmodified. The arbiter does no sign handling; two's-complement interpretation belongs to the datapath.
- A req still high in the cycle after its grant counts as a new request.
- Requests arriving while busy wait; there is no queueing beyond the req level.
- mult_A/mult_B hold opA/opB in all states. gnt, mult_start and rsp_valid are 0 outside their states.

## Timing
- Reset, immediate and asynchronous:
  - State=IDLE, last_id=1, so port 0 wins the first tie.
  - opA, opB, timer, rsp_data and rsp_timeout are cleared.
  - All outputs are 0.
- Reset mid-operation aborts the operation. No gnt or rsp is issued for it, and mult_start is low.
- req0 high in IDLE cycle t produces:
  - gnt0 and mult_start in cycle t+1
  - first WAIT cycle at t+2 (timer=0)
  - earliest accepted done at t+3
  - rsp_valid at t+4
  - IDLE again at t+5
- If done is sampled in WAIT cycle k, rsp_valid is asserted in cycle k+1.
- Timeout path: rsp_valid occurs TIMEOUT+1 cycles after the first WAIT cycle.
- Back-to-back operations: the next grant comes 2 cycles after rsp_valid, at the earliest.
- gnt, mult_start and rsp_valid are registered Moore outputs with no combinational path from inputs.

## Test plan
- **Single request:** req0, a0=3, b0=5; model asserts done 4 cycles after start with out=15 -> gnt0 one cycle, mult_start one cycle, mult_A=3, mult_B=5, then rsp_valid with id=0, data=0x000F, timeout=0.
- **Round robin:** req0 and req1 both high from reset, each re-raised after its grant -> grant order 0,1,0,1. Each rsp_id matches its grant, and the two gnts are never high together.
- **Signed passthrough:** a1=0xFC (-4), b1=0x07, model out=0xFFE4 -> mult_A=0xFC, rsp_data=0xFFE4, rsp_id=1.
- **Timeout:** mult_done held 0 -> rsp_valid exactly TIMEOUT+1 cycles after the first WAIT cycle, with rsp_timeout=1 and rsp_data=0. A following request is then served normally.
- **Stale done:** mult_done held high through the first WAIT cycle, drops, then rises 3 cycles later -> response only after the later rise. In a variant where done stays high, the response comes at timer=1.
- **Reset in WAIT:** reset_L pulsed low mid-WAIT with req1 pending -> all outputs 0 asynchronously and no rsp. After release with req0 and req1 both high, port 0 is granted first.

Source files
------------

// File: rtl/mult_share_arb.sv
// Round-robin arbiter and sequencer that shares one signed 8x8 multiplier between two clients.
// state  | meaning
// IDLE   | waiting for a request; the winner's operands are captured on the way out
// START  | gnt and mult_start pulse, timer cleared
// WAIT   | waiting for mult_done (ignored at timer==0) or timeout
// RESP   | rsp_valid pulse, last_id updated
module mult_share_arb #(
    parameter int TIMEOUT = 24
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        mult_start,
    output logic [7:0]  mult_A,
    output logic [7:0]  mult_B,
    input  logic        mult_done,
    input  logic [15:0] mult_out,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [4:0] TO_CNT = 5'(TIMEOUT);

    state_t      r_state;
    logic [7:0]  r_op_a;
    logic [7:0]  r_op_b;
    logic        r_cur_id;
    logic        r_last_id;
    logic [4:0]  r_timer;
    logic [15:0] r_rsp_data;
    logic        r_rsp_timeout;
    logic        r_rsp_id;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_start;
    logic        r_rsp_valid;

    logic        w_any_req;
    logic        w_win_id;

    // On a tie the port that was not served last wins.
    assign w_any_req = req0 | req1;
    assign w_win_id  = (req0 & req1) ? ~r_last_id : req1;

    // Pulse outputs are registered on entry to the state they belong to.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state       <= S_IDLE;
            r_op_a        <= 8'd0;
            r_op_b        <= 8'd0;
            r_cur_id      <= 1'b0;
            r_last_id     <= 1'b1;
            r_timer       <= 5'd0;
            r_rsp_data    <= 16'd0;
            r_rsp_timeout <= 1'b0;
            r_rsp_id      <= 1'b0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_start       <= 1'b0;
            r_rsp_valid   <= 1'b0;
        end else begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_start     <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_op_a   <= w_win_id ? a1 : a0;
                        r_op_b   <= w_win_id ? b1 : b0;
                        r_cur_id <= w_win_id;
                        r_gnt0   <= ~w_win_id;
                        r_gnt1   <= w_win_id;
                        r_start  <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    r_timer <= 5'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done level seen at timer==0 may be left over from the previous operation.
                    if ((r_timer != 5'd0) && mult_done) begin
                        r_rsp_data    <= mult_out;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_id      <= r_cur_id;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_timer == TO_CNT) begin
                        r_rsp_data    <= 16'd0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_id      <= r_cur_id;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 5'd1;
                    end
                end
                S_RESP: begin
                    r_last_id <= r_cur_id;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign mult_start  = r_start;
    assign mult_A      = r_op_a;
    assign mult_B      = r_op_b;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = (r_state != S_IDLE);

endmodule
